// File: rtl/mem_addr_arbiter_if.sv
// Request/memory bundle for mem_addr_arbiter.
// master = requesters + memory, slave = arbiter.
interface mem_addr_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 28,
  parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*ADDR_W-1:0] addr_in;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_valid;
  logic [NUM_CH-1:0]        grant;
  logic [ID_W-1:0]          grant_id;
  logic [NUM_CH-1:0]        ack;

  modport master (
    output req,
    output addr_in,
    output mem_ready,
    input  mem_addr,
    input  mem_valid,
    input  grant,
    input  grant_id,
    input  ack
  );

  modport slave (
    input  req,
    input  addr_in,
    input  mem_ready,
    output mem_addr,
    output mem_valid,
    output grant,
    output grant_id,
    output ack
  );
endinterface

// File: rtl/mem_addr_arbiter.sv
// NUM_CH-way address arbiter onto one registered memory port.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module mem_addr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 28,
  parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic               clk,
  input logic               rst,
  mem_addr_arbiter_if.slave bus
);
  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   win;
  logic [ADDR_W-1:0] win_addr;
  logic              any_req;
  logic              hs;

  assign any_req = |bus.req;
  assign hs      = bus.mem_valid & bus.mem_ready;
  assign bus.ack = bus.grant & {NUM_CH{hs}};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     nxt_ptr;
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;

  function automatic int wrap(int s);
    return (s >= NUM_CH) ? s - NUM_CH : s;
  endfunction

  // rot[k] is the request of channel (ptr + k) mod NUM_CH
  assign dbl = {bus.req, bus.req} >> ptr;
  assign rot = dbl[NUM_CH-1:0];

  always_comb begin
    win = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        win = ID_W'(wrap(int'(ptr) + k));
      end
    end
  end

  assign nxt_ptr = ID_W'(wrap(int'(win) + 1));
`else
  always_comb begin
    win = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        win = ID_W'(k);
      end
    end
  end
`endif

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == ID_W'(i)) begin
        win_addr = bus.addr_in[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.mem_addr  <= '0;
      bus.mem_valid <= 1'b0;
      bus.grant     <= '0;
      bus.grant_id  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr           <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state         <= BUSY;
            bus.mem_addr  <= win_addr;
            bus.mem_valid <= 1'b1;
            bus.grant     <= NUM_CH'(1) << win;
            bus.grant_id  <= win;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr           <= nxt_ptr;
`endif
          end
        end
        BUSY: begin
          // address and owner stay frozen until the memory takes it
          if (hs) begin
            state         <= IDLE;
            bus.mem_valid <= 1'b0;
            bus.grant     <= '0;
            bus.grant_id  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(bus.grant));
      assert (bus.mem_valid == (bus.grant != '0));
      assert (bus.mem_valid == (state == BUSY));
    end
  end
endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Self-checking bench for mem_addr_arbiter (NUM_CH=4).
// Build with MEM_ARB_ROUND_ROBIN_EN to check round-robin.
module tb_mem_addr_arbiter;
  localparam int N  = 4;
  localparam int AW = 28;

  typedef logic [AW-1:0] addr_t;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    addr_t        a0;
    addr_t        a1;
    logic         rdy;
    logic         ev;
    logic [N-1:0] eg;
    logic [1:0]   eid;
    addr_t        ea;
    logic [N-1:0] eack;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_addr_arbiter_if #(.NUM_CH(N), .ADDR_W(AW)) bus ();

  mem_addr_arbiter #(.NUM_CH(N), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic         c_rst;
  logic [N-1:0] c_req;
  logic         c_rdy;
  addr_t        a[N];

  bit    m_busy;
  int    m_own;
  addr_t m_addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  int    m_ptr;
  int    rr_exp[5] = '{0, 1, 2, 3, 0};
`else
  int    rr_exp[5] = '{0, 0, 0, 0, 0};
`endif

  vec_t tbl[23];

  function automatic vec_t mk(
    logic r, logic [N-1:0] q, addr_t x0, addr_t x1, logic rd,
    logic ev, logic [N-1:0] eg, logic [1:0] eid, addr_t ea,
    logic [N-1:0] eack);
    vec_t v;
    v.rst = r; v.req = q; v.a0 = x0; v.a1 = x1; v.rdy = rd;
    v.ev = ev; v.eg = eg; v.eid = eid; v.ea = ea; v.eack = eack;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] r);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (r[c[1:0]]) return c;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (r[k]) return k;
    end
`endif
    return 0;
  endfunction

  task automatic apply(logic r, logic [N-1:0] q, addr_t x0, addr_t x1,
                       addr_t x2, addr_t x3, logic rd);
    c_rst = r; c_req = q; c_rdy = rd;
    a[0] = x0; a[1] = x1; a[2] = x2; a[3] = x3;
    rst = r;
    bus.req = q;
    bus.addr_in = {x3, x2, x1, x0};
    bus.mem_ready = rd;
    #4;
  endtask

  task automatic chk_model();
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_own) : '0;
    chk("model_valid", bus.mem_valid, m_busy);
    chk("model_grant", bus.grant, eg);
    chk("model_gid", bus.grant_id, m_busy ? m_own : 0);
    chk("model_addr", bus.mem_addr, m_addr);
    chk("model_ack", bus.ack, (m_busy && c_rdy) ? eg : '0);
  endtask

  task automatic tick();
    int w;
    @(posedge clk);
    if (c_rst) begin
      m_busy = 0; m_own = 0; m_addr = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_ptr = 0;
`endif
    end else if (!m_busy) begin
      if (c_req != '0) begin
        w = pick(c_req);
        m_busy = 1; m_own = w; m_addr = a[2'(w)];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_ptr = (w + 1) % N;
`endif
      end
    end else if (c_rdy) begin
      m_busy = 0;
    end
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1, 4'b0011, 28'h5A5A5A5, 28'h0A5A5A5, 0, 0, 4'b0000, 0, 28'h0, 4'b0000);
    tbl[1]  = mk(1, 4'b0011, 28'h5A5A5A5, 28'h0A5A5A5, 0, 0, 4'b0000, 0, 28'h0, 4'b0000);
    tbl[2]  = mk(0, 4'b0000, 28'h5A5A5A5, 28'h0A5A5A5, 1, 0, 4'b0000, 0, 28'h0, 4'b0000);
    tbl[3]  = mk(0, 4'b0000, 28'h5A5A5A5, 28'h0A5A5A5, 1, 0, 4'b0000, 0, 28'h0, 4'b0000);
    tbl[4]  = mk(0, 4'b0010, 28'h0, 28'h0000123, 1, 0, 4'b0000, 0, 28'h0, 4'b0000);
    tbl[5]  = mk(0, 4'b0010, 28'h0, 28'h0000123, 1, 1, 4'b0010, 1, 28'h0000123, 4'b0010);
    tbl[6]  = mk(0, 4'b0000, 28'h0, 28'h0000123, 1, 0, 4'b0000, 0, 28'h0000123, 4'b0000);
    tbl[7]  = mk(0, 4'b0011, 28'hBCDEF01, 28'h2345678, 0, 0, 4'b0000, 0, 28'h0000123, 4'b0000);
    tbl[8]  = mk(0, 4'b0011, 28'hBCDEF01, 28'h2345678, 0, 1, 4'b0001, 0, 28'hBCDEF01, 4'b0000);
    tbl[9]  = mk(0, 4'b0011, 28'hBCDEF01, 28'h2345678, 0, 1, 4'b0001, 0, 28'hBCDEF01, 4'b0000);
    tbl[10] = mk(0, 4'b0011, 28'hBCDEF01, 28'h2345678, 0, 1, 4'b0001, 0, 28'hBCDEF01, 4'b0000);
    tbl[11] = mk(0, 4'b0011, 28'hBCDEF01, 28'h2345678, 1, 1, 4'b0001, 0, 28'hBCDEF01, 4'b0001);
    tbl[12] = mk(0, 4'b0010, 28'hBCDEF01, 28'h2345678, 1, 0, 4'b0000, 0, 28'hBCDEF01, 4'b0000);
    tbl[13] = mk(0, 4'b0010, 28'hBCDEF01, 28'h2345678, 1, 1, 4'b0010, 1, 28'h2345678, 4'b0010);
    tbl[14] = mk(0, 4'b0000, 28'hBCDEF01, 28'h2345678, 0, 0, 4'b0000, 0, 28'h2345678, 4'b0000);
    tbl[15] = mk(0, 4'b0001, 28'hFFFFFFF, 28'h2345678, 0, 0, 4'b0000, 0, 28'h2345678, 4'b0000);
    tbl[16] = mk(0, 4'b0011, 28'h0000001, 28'h2345678, 0, 1, 4'b0001, 0, 28'hFFFFFFF, 4'b0000);
    tbl[17] = mk(0, 4'b0001, 28'h0000001, 28'h2345678, 0, 1, 4'b0001, 0, 28'hFFFFFFF, 4'b0000);
    tbl[18] = mk(0, 4'b0011, 28'h0000001, 28'h2345678, 0, 1, 4'b0001, 0, 28'hFFFFFFF, 4'b0000);
    tbl[19] = mk(0, 4'b0001, 28'h0000001, 28'h2345678, 0, 1, 4'b0001, 0, 28'hFFFFFFF, 4'b0000);
    tbl[20] = mk(0, 4'b0011, 28'h0000001, 28'h2345678, 0, 1, 4'b0001, 0, 28'hFFFFFFF, 4'b0000);
    tbl[21] = mk(0, 4'b0001, 28'h0000001, 28'h2345678, 1, 1, 4'b0001, 0, 28'hFFFFFFF, 4'b0001);
    tbl[22] = mk(0, 4'b0000, 28'h0000001, 28'h2345678, 0, 0, 4'b0000, 0, 28'hFFFFFFF, 4'b0000);

    apply(1, 4'b0011, 28'h0, 28'h0, 28'h0, 28'h0, 0);
    tick();

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].a0, tbl[i].a1,
            28'h0, 28'h0, tbl[i].rdy);
      chk_model();
      chk($sformatf("tbl%0d_valid", i), bus.mem_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_grant", i), bus.grant, tbl[i].eg);
      chk($sformatf("tbl%0d_gid", i), bus.grant_id, tbl[i].eid);
      chk($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_ack", i), bus.ack, tbl[i].eack);
      tick();
    end

    apply(1, 4'b0000, 28'h0, 28'h0, 28'h0, 28'h0, 0);
    tick();
    for (int t = 0; t < 10; t++) begin
      apply(0, 4'b1111, 28'h1000000, 28'h2000000, 28'h3000000, 28'h4000000, 1);
      chk_model();
      if (t % 2 == 1) begin
        chk($sformatf("rr_valid%0d", t / 2), bus.mem_valid, 1);
        chk($sformatf("rr_gid%0d", t / 2), bus.grant_id, rr_exp[t / 2]);
      end
      tick();
    end

    apply(1, 4'b0000, 28'h0, 28'h0, 28'h0, 28'h0, 0);
    tick();
    apply(0, 4'b0100, 28'h0, 28'h0, 28'hABCDEF0, 28'h0, 0);
    chk_model();
    tick();
    apply(0, 4'b0100, 28'h0, 28'h0, 28'hABCDEF0, 28'h0, 0);
    chk_model();
    chk("midrst_grant", bus.grant, 4'b0100);
    chk("midrst_addr", bus.mem_addr, 28'hABCDEF0);
    tick();
    apply(1, 4'b1010, 28'h0, 28'h1111111, 28'hABCDEF0, 28'h3333333, 0);
    chk_model();
    chk("midrst_noack", bus.ack, 4'b0000);
    tick();
    apply(0, 4'b1010, 28'h0, 28'h1111111, 28'hABCDEF0, 28'h3333333, 0);
    chk_model();
    chk("postrst_valid", bus.mem_valid, 0);
    chk("postrst_grant", bus.grant, 4'b0000);
    chk("postrst_ack", bus.ack, 4'b0000);
    tick();
    apply(0, 4'b1010, 28'h0, 28'h1111111, 28'hABCDEF0, 28'h3333333, 1);
    chk_model();
    chk("rearb_grant", bus.grant, 4'b0010);
    chk("rearb_gid", bus.grant_id, 1);
    chk("rearb_addr", bus.mem_addr, 28'h1111111);
    tick();

    apply(1, 4'b0000, 28'h0, 28'h0, 28'h0, 28'h0, 0);
    tick();
    for (int t = 0; t < 400; t++) begin
      addr_t x[N];
      for (int c = 0; c < N; c++) begin
        int s;
        s = int'($urandom_range(7));
        if (s == 0) x[c] = '0;
        else if (s == 1) x[c] = '1;
        else x[c] = AW'($urandom);
      end
      apply($urandom_range(39) == 0, N'($urandom), x[0], x[1], x[2], x[3],
            1'($urandom_range(1)));
      chk_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
